// File: rtl/seg_scanner_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table,
// blank pattern, digit count and the glyph lookup helper.
package seg_scanner_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // gfedcba, active-high, entry n is the glyph for hex digit n
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] hex7(input logic [3:0] n);
      return HEX7_TABLE[n];
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble + dot to active-low {dp,g,f,e,d,c,b,a}.
// Ports: nibble (hex value), dot (1 = lit), pattern (active-low).
module seg_decoder
   import seg_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dot,
   output logic [7:0] pattern
);

   assign pattern = ~{dot, hex7(nibble)};

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed 8-digit seven-segment driver with tear-free frame loads.
// Ports: clk, rst (async high); digits/dot/enable/blink captured on load;
// seg_en/seg_out active-low registered outputs; updated pulses on apply.
module seg_scanner
   import seg_scanner_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digits,
   input  logic [7:0]  dot,
   input  logic [7:0]  enable,
   input  logic [7:0]  blink,
   input  logic        load,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out,
   output logic        updated
);

   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);

   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   logic [31:0] sh_digits, act_digits;
   logic [7:0]  sh_dot, act_dot;
   logic [7:0]  sh_en, act_en;
   logic [7:0]  sh_blink, act_blink;
   logic        pending;
   logic        xfer_q;

   logic       scan_tc;
   logic       blink_tc;
   logic       frame_end;
   logic       visible;
   logic [3:0] cur_nibble;
   logic [7:0] cur_pattern;

   assign scan_tc    = (scan_cnt == SCAN_LAST);
   assign blink_tc   = (blink_cnt == BLINK_LAST);
   assign frame_end  = scan_tc && (idx == IDX_LAST);
   assign cur_nibble = act_digits[{idx, 2'b00} +: 4];
   assign visible    = act_en[idx] & (~act_blink[idx] | phase);

   seg_decoder u_dec (
      .nibble  (cur_nibble),
      .dot     (act_dot[idx]),
      .pattern (cur_pattern)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_tc) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_tc) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_digits <= '0;
         sh_dot    <= '0;
         sh_en     <= '0;
         sh_blink  <= '0;
      end else if (load) begin
         sh_digits <= digits;
         sh_dot    <= dot;
         sh_en     <= enable;
         sh_blink  <= blink;
      end
   end

   // A load on the frame-end edge wins over the clear, so the freshly
   // captured values wait for the following frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= 1'b0;
      else if (load)
         pending <= 1'b1;
      else if (frame_end)
         pending <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_digits <= '0;
         act_dot    <= '0;
         act_en     <= '0;
         act_blink  <= '0;
      end else if (frame_end && pending) begin
         act_digits <= sh_digits;
         act_dot    <= sh_dot;
         act_en     <= sh_en;
         act_blink  <= sh_blink;
      end
   end

   // Delayed by one so the pulse lines up with digit 0 of the new frame
   // reaching the registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_q  <= 1'b0;
         updated <= 1'b0;
      end else begin
         xfer_q  <= frame_end & pending;
         updated <= xfer_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_en  <= SEG_BLANK;
         seg_out <= SEG_BLANK;
      end else if (visible) begin
         seg_en  <= ~(8'd1 << idx);
         seg_out <= cur_pattern;
      end else begin
         seg_en  <= SEG_BLANK;
         seg_out <= SEG_BLANK;
      end
   end

endmodule

// File: doc/seg_scanner.md
# seg_scanner

Multiplexed 8-digit seven-segment display driver. It is the output-side counterpart of the switch/button/keypad input path, and sits between game or display logic and the board's common-select segment pins. It latches a frame of hex digits, per-digit dot, enable and blink flags through a load handshake. Latched contents are applied only at frame boundaries, so partial updates never tear, and the driver scans one digit per slot with active-low select and segment outputs.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz).
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `digits`  in  32  eight hex nibbles; nibble i (bits 4i+3:4i) drives digit i.
- `dot`  in  8  per-digit decimal point, 1 = lit.
- `enable`  in  8  per-digit enable, 1 = shown.
- `blink`  in  8  per-digit blink, 1 = blinks.
- `load`  in  1  one-cycle strobe that captures `digits`, `dot`, `enable` and `blink`.
- `seg_en`  out  8  digit selects, active-low, one-hot-low or all high.
- `seg_out`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `updated`  out  1  one-cycle pulse when a loaded frame becomes active.

## Operation
- **Shadow register.** A cycle with `load`=1 copies the four inputs into the shadow registers and sets `pending`. Several loads before a frame end: the last one wins, and only one `updated` pulse is produced.
- **Active register.** The active registers drive the display.
- **Scan counter.** `scan_cnt` counts 0..`SCAN_DIV`-1. At its terminal count, `idx` advances 0→1→…→7→0.
- **Frame end.** A frame end is the terminal count while `idx`=7. At a frame end with `pending` set: active ← shadow, `pending` cleared, `updated`=1 next cycle.
- **Load at frame end.** `load` coincident with a frame end: the transfer uses the shadow contents before that edge, the new values land in shadow, and `pending` stays set for the next frame.
- **Blink counter.** Free-running counter 0..`BLINK_DIV`-1. `phase` toggles at its terminal count. `phase`=1 after reset means visible.
- **Digit i visible** when `enable[i]` & (~`blink[i]` | `phase`).
- **Visible slot:** `seg_en` = ~(1<<idx), `seg_out` = ~{dot[idx], hex7(nibble idx)}.
- **Blanked slot:** `seg_en`=8'hFF, `seg_out`=8'hFF.
- **hex7 encoding**, gfedcba active-high: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.

## Timing
- **Reset values:** `seg_en`=8'hFF, `seg_out`=8'hFF, `updated`=0; `idx`=0, `scan_cnt`=0, blink counter 0, `phase`=1, `pending`=0; shadow and active registers all zero. The display is dark until the first load.
- **Output registration.** `seg_en` and `seg_out` are registered. The pattern for slot `idx` appears one cycle after `idx` takes that value and holds for `SCAN_DIV` cycles.
- **Frame period:** 8·`SCAN_DIV` cycles.
- **Load-to-display latency.**
  - `updated` asserts the cycle after the frame-end edge.
  - Digit 0 of the new frame shows on that same cycle.
  - Worst case from `load` is 8·`SCAN_DIV`+1 cycles.
- **Reset mid-operation.** Reset asserted mid-frame blanks the outputs immediately (asynchronous) and discards `pending`.
- **Blink edge.** A blink toggle mid-slot takes effect on the next registered output cycle; it does not wait for a slot boundary.

## Structure
- **Shared constants file:** the hex7 pattern constants, the blank pattern 8'hFF, and the digit count 8.
- **Sub-module `seg_decoder`:** combinational nibble + dot → active-low 8-bit pattern, instantiated once on the `idx`-selected nibble.
- **Top:** scan counter, blink counter, shadow/active registers, `pending` flag and output registers.

## Test plan
All scenarios use `SCAN_DIV`=4, `BLINK_DIV`=64.
- Reset, no load, run 100 cycles → `seg_en`=FF, `seg_out`=FF, `updated` never asserts.
- Load `digits`=32'h76543210, `enable`=FF, `dot`=0, `blink`=0 at cycle 3 → `updated` pulses once after the first frame end. Slots then show `seg_en` FE…7F in order, with `seg_out` C0, F9, A4, B0, 99, 92, 82, F8, each held 4 cycles.
- `digits`=8 on all digits, `dot`=8'h01, `enable`=8'h01 → slot 0 shows `seg_out`=00, slots 1–7 show `seg_en`=FF.
- Two loads (first `digits`=AAAAAAAA, then `digits`=FFFFFFFF) within one frame → a single `updated` pulse, and the displayed value is F (8E), never A (88).
- Load coincident with the frame-end edge → the previous shadow is applied at that edge, and the new value is applied one frame (32 cycles) later with a second `updated` pulse.
- `blink`=8'h01, `enable`=FF → digit 0 is dark for 64 cycles and visible for 64 cycles, alternating, while the other digits stay steady.
- Assert `rst` mid-slot → outputs go to FF the same cycle. After release, the display stays dark until a new load.
